// File: rtl/clk_div_monitor.sv
// Health monitor for a divided clock: samples clk_mon in the clkin domain, measures its
// period and high time, asserts locked after LOCK_CNT good periods and keeps a sticky err.
module clk_div_monitor #(
    parameter int DIV      = 5,
    parameter int LOCK_CNT = 4,
    parameter int CW       = 8
) (
    input  logic          clkin,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clk_mon,
    input  logic          err_clr,
    output logic [CW-1:0] period,
    output logic [CW-1:0] high_cnt,
    output logic          meas_valid,
    output logic          locked,
    output logic          err
);
    localparam int            GW      = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] DIV_C   = CW'(DIV);
    localparam logic [CW-1:0] TMO_C   = CW'(2 * DIV);
    localparam logic [CW-1:0] HMIN_C  = CW'(DIV / 2);
    localparam logic [CW-1:0] HMAX_C  = CW'((DIV + 1) / 2);
    localparam logic [GW-1:0] LOCK_C  = GW'(LOCK_CNT);

    typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, LOCKED} state_t;
    state_t state_reg, state_next;

    // sync_reg[0..2] = s1, s2, s3
    logic [2:0]    sync_reg;
    logic [CW-1:0] pcnt_reg, pcnt_next;
    logic [CW-1:0] hcnt_reg, hcnt_next;
    logic [CW-1:0] period_reg, period_next;
    logic [CW-1:0] high_reg, high_next;
    logic [GW-1:0] gcnt_reg, gcnt_next;
    logic          meas_reg, meas_next;
    logic          locked_reg, locked_next;
    logic          err_reg, err_next;
    logic          rise, good, timeout, err_set;

    assign rise = sync_reg[1] & ~sync_reg[2];
    assign good = (pcnt_reg == DIV_C) && (hcnt_reg >= HMIN_C) && (hcnt_reg <= HMAX_C);
    // ACQUIRE is only ever occupied before its first rise, so it never times out.
    assign timeout = !rise && (pcnt_reg == TMO_C) &&
                     ((state_reg == TRACK) || (state_reg == LOCKED));

    always_comb begin
        state_next  = state_reg;
        pcnt_next   = pcnt_reg;
        hcnt_next   = hcnt_reg;
        gcnt_next   = gcnt_reg;
        period_next = period_reg;
        high_next   = high_reg;
        meas_next   = 1'b0;
        locked_next = locked_reg;
        err_set     = 1'b0;

        if (!en) begin
            state_next  = IDLE;
            pcnt_next   = '0;
            hcnt_next   = '0;
            gcnt_next   = '0;
            locked_next = 1'b0;
        end else begin
            if (state_reg != IDLE) begin
                if (rise) begin
                    pcnt_next = CW'(1);
                    hcnt_next = CW'(1);
                end else begin
                    pcnt_next = (pcnt_reg == CNT_MAX) ? CNT_MAX : pcnt_reg + CW'(1);
                    hcnt_next = (sync_reg[1] && hcnt_reg != CNT_MAX) ? hcnt_reg + CW'(1)
                                                                      : hcnt_reg;
                end
            end

            case (state_reg)
                IDLE: state_next = ACQUIRE;
                ACQUIRE: begin
                    if (rise) begin
                        state_next = TRACK;
                        gcnt_next  = '0;
                    end
                end
                TRACK, LOCKED: begin
                    if (rise) begin
                        period_next = pcnt_reg;
                        high_next   = hcnt_reg;
                        meas_next   = 1'b1;
                        if (!good) begin
                            err_set     = 1'b1;
                            gcnt_next   = '0;
                            locked_next = 1'b0;
                            state_next  = TRACK;
                        end else if (state_reg == TRACK) begin
                            gcnt_next = gcnt_reg + GW'(1);
                            if ((gcnt_reg + GW'(1)) == LOCK_C) begin
                                state_next  = LOCKED;
                                locked_next = 1'b1;
                            end
                        end
                    end else if (timeout) begin
                        err_set     = 1'b1;
                        locked_next = 1'b0;
                        gcnt_next   = '0;
                        state_next  = ACQUIRE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        // a fault in the same cycle as err_clr must not be lost
        err_next = err_set ? 1'b1 : (err_clr ? 1'b0 : err_reg);
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            sync_reg   <= '0;
            pcnt_reg   <= '0;
            hcnt_reg   <= '0;
            gcnt_reg   <= '0;
            period_reg <= '0;
            high_reg   <= '0;
            meas_reg   <= 1'b0;
            locked_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            sync_reg   <= {sync_reg[1:0], clk_mon};
            pcnt_reg   <= pcnt_next;
            hcnt_reg   <= hcnt_next;
            gcnt_reg   <= gcnt_next;
            period_reg <= period_next;
            high_reg   <= high_next;
            meas_reg   <= meas_next;
            locked_reg <= locked_next;
            err_reg    <= err_next;
        end
    end

    assign period     = period_reg;
    assign high_cnt   = high_reg;
    assign meas_valid = meas_reg;
    assign locked     = locked_reg;
    assign err        = err_reg;
endmodule

// File: tb/tb_clk_div_monitor.sv
// Randomized bench for clk_div_monitor: clk_mon is generated as a per-cycle bit stream and
// every output is compared each cycle against a waveform-level model of the monitor rules.
module tb_clk_div_monitor;
    localparam int DIV      = 5;
    localparam int LOCK_CNT = 4;
    localparam int CW       = 8;
    localparam int MAXN     = 8192;

    logic          clkin   = 1'b0;
    logic          rst_n   = 1'b0;
    logic          en      = 1'b0;
    logic          clk_mon = 1'b0;
    logic          err_clr = 1'b0;
    logic [CW-1:0] period, high_cnt;
    logic          meas_valid, locked, err;
    logic [2*CW+2:0] got_v;

    clk_div_monitor #(.DIV(DIV), .LOCK_CNT(LOCK_CNT), .CW(CW)) dut (
        .clkin(clkin), .rst_n(rst_n), .en(en), .clk_mon(clk_mon), .err_clr(err_clr),
        .period(period), .high_cnt(high_cnt), .meas_valid(meas_valid),
        .locked(locked), .err(err)
    );

    always #5 clkin = ~clkin;
    assign got_v = {period, high_cnt, meas_valid, locked, err};

    int checks = 0;
    int errors = 0;

    // clk_mon value driven before clkin edge k; entries below floor_n were flushed by reset
    bit hist [MAXN];
    int n = 0;
    int floor_n = 0;
    int last_meas_edge = -1;
    bit wq [$];

    // reference: rises are taken from the recorded stream, measurements by plain arithmetic
    bit m_active, m_have_ref, m_meas, m_locked, m_err;
    int m_last, m_good_run, m_period, m_high;

    function automatic bit hb(int k);
        return (k >= floor_n && k >= 0) ? hist[k] : 1'b0;
    endfunction

    function automatic bit will_rise();
        return hb(n - 2) && !hb(n - 3);
    endfunction

    function automatic logic [2*CW+2:0] exp_vec();
        return {m_period[CW-1:0], m_high[CW-1:0], m_meas, m_locked, m_err};
    endfunction

    task automatic model_reset();
        m_active = 0; m_have_ref = 0; m_meas = 0; m_locked = 0; m_err = 0;
        m_last = 0; m_good_run = 0; m_period = 0; m_high = 0;
    endtask

    task automatic model_edge(input bit en_v, input bit clr_v);
        bit rise, err_set;
        int p, h;
        rise    = hb(n - 2) && !hb(n - 3);
        err_set = 0;
        m_meas  = 0;
        if (!en_v) begin
            m_active = 0; m_have_ref = 0; m_good_run = 0; m_locked = 0;
        end else if (!m_active) begin
            m_active = 1;
        end else if (rise) begin
            if (m_have_ref) begin
                p = n - m_last;
                h = 0;
                for (int k = m_last - 2; k <= n - 3; k++) h += int'(hb(k));
                m_period = p; m_high = h; m_meas = 1;
                if (p == DIV && h >= DIV / 2 && h <= (DIV + 1) / 2) begin
                    m_good_run++;
                    if (m_good_run == LOCK_CNT) m_locked = 1;
                end else begin
                    err_set = 1; m_good_run = 0; m_locked = 0;
                end
            end else begin
                m_good_run = 0;
            end
            m_have_ref = 1;
            m_last = n;
        end else if (m_have_ref && (n - m_last) == 2 * DIV) begin
            err_set = 1; m_locked = 0; m_have_ref = 0; m_good_run = 0;
        end
        if (err_set) m_err = 1;
        else if (clr_v) m_err = 0;
    endtask

    task automatic step(input bit b, input bit en_v, input bit clr_v);
        @(negedge clkin);
        clk_mon = b; en = en_v; err_clr = clr_v; hist[n] = b;
        @(posedge clkin);
        model_edge(en_v, clr_v);
        n++;
        #1;
        if (meas_valid) begin
            last_meas_edge = n - 1;
            $display("meas edge=%0d period=%0d high_cnt=%0d locked=%b err=%b",
                     n - 1, period, high_cnt, locked, err);
        end
    endtask

    task automatic push_period(input int p, input int h);
        for (int i = 0; i < p; i++) wq.push_back(i < h);
    endtask

    task automatic release_reset();
        @(negedge clkin);
        rst_n = 1'b1;
        floor_n = n;
        model_reset();
    endtask

    task automatic test_reset();
        @(posedge clkin); #1;
        if (got_v !== '0) begin
            errors++;
            $display("FAIL reset got=%h expected=0", got_v);
        end
        checks++;
        release_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (got_v !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle edge=%0d got=%h expected=%h", n - 1, got_v, exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_lock();
        int mcount, lock_meas;
        bit b;
        mcount = 0; lock_meas = -1;
        wq.delete();
        push_period(2, 0);
        for (int i = 0; i < 7; i++) push_period(DIV, int'($urandom_range(2, 3)));
        while (wq.size() > 0) begin
            b = wq.pop_front();
            step(b, 1'b1, 1'b0);
            if (meas_valid) mcount++;
            if (locked && lock_meas < 0) lock_meas = mcount;
            if (got_v !== exp_vec()) begin
                errors++;
                $display("FAIL lock edge=%0d got=%h expected=%h", n - 1, got_v, exp_vec());
            end
            checks++;
        end
        if (lock_meas !== LOCK_CNT) begin
            errors++;
            $display("FAIL lock_at_meas got=%0d expected=%0d", lock_meas, LOCK_CNT);
        end
        checks++;
    endtask

    task automatic test_bad_period();
        bit b, saw6;
        saw6 = 0;
        wq.delete();
        push_period(DIV + 1, 3);
        for (int i = 0; i < 6; i++) push_period(DIV, int'($urandom_range(2, 3)));
        while (wq.size() > 0) begin
            b = wq.pop_front();
            step(b, 1'b1, 1'b0);
            if (meas_valid && period == CW'(DIV + 1)) saw6 = 1;
            if (got_v !== exp_vec()) begin
                errors++;
                $display("FAIL bad_period edge=%0d got=%h expected=%h", n - 1, got_v, exp_vec());
            end
            checks++;
        end
        if ({saw6, locked, err} !== 3'b111) begin
            errors++;
            $display("FAIL relock saw6/locked/err got=%b expected=111", {saw6, locked, err});
        end
        checks++;
    endtask

    task automatic test_timeout();
        int fall_edge;
        fall_edge = -1;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, i == 0);
            if (!locked && fall_edge < 0) fall_edge = n - 1;
            if (got_v !== exp_vec()) begin
                errors++;
                $display("FAIL timeout edge=%0d got=%h expected=%h", n - 1, got_v, exp_vec());
            end
            checks++;
        end
        if (fall_edge - last_meas_edge !== 2 * DIV || err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_delay got=%0d err=%b expected=%0d err=1",
                     fall_edge - last_meas_edge, err, 2 * DIV);
        end
        checks++;
    endtask

    task automatic test_duty();
        bit b, saw_lock;
        saw_lock = 0;
        wq.delete();
        for (int i = 0; i < 8; i++) push_period(DIV, 1);
        step(1'b0, 1'b1, 1'b1);
        while (wq.size() > 0) begin
            b = wq.pop_front();
            step(b, 1'b1, 1'b0);
            if (locked) saw_lock = 1;
            if (got_v !== exp_vec()) begin
                errors++;
                $display("FAIL duty edge=%0d got=%h expected=%h", n - 1, got_v, exp_vec());
            end
            checks++;
        end
        if ({saw_lock, err} !== 2'b01 || high_cnt !== CW'(1)) begin
            errors++;
            $display("FAIL duty_end lock/err=%b high_cnt=%0d expected lock/err=01 high_cnt=1",
                     {saw_lock, err}, high_cnt);
        end
        checks++;
    endtask

    task automatic test_err_clr();
        bit b, clr, clash_err;
        clash_err = 0;
        wq.delete();
        step(1'b0, 1'b1, 1'b1);
        push_period(DIV, 3); push_period(DIV, 2);
        push_period(DIV + 2, 3);
        push_period(DIV, 3); push_period(DIV, 2);
        while (wq.size() > 0) begin
            b = wq.pop_front();
            clr = will_rise() && m_have_ref && (n - m_last) != DIV;
            step(b, 1'b1, clr);
            if (clr) clash_err = err;
            if (got_v !== exp_vec()) begin
                errors++;
                $display("FAIL err_clr edge=%0d got=%h expected=%h", n - 1, got_v, exp_vec());
            end
            checks++;
        end
        if (clash_err !== 1'b1) begin
            errors++;
            $display("FAIL set_beats_clr got=%b expected=1", clash_err);
        end
        checks++;
        step(1'b0, 1'b1, 1'b1);
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL clr_alone got=%b expected=0", err);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        bit b;
        int p_before;
        wq.delete();
        for (int i = 0; i < 7; i++) push_period(DIV, int'($urandom_range(2, 3)));
        while (wq.size() > 0) begin
            b = wq.pop_front();
            step(b, 1'b1, 1'b0);
            if (got_v !== exp_vec()) begin
                errors++;
                $display("FAIL pre_reset edge=%0d got=%h expected=%h", n - 1, got_v, exp_vec());
            end
            checks++;
        end
        rst_n = 1'b0;
        #1;
        if (got_v !== '0) begin
            errors++;
            $display("FAIL async_reset got=%h expected=0", got_v);
        end
        checks++;
        @(negedge clkin);
        en = 1'b0; clk_mon = 1'b0; err_clr = 1'b0;
        release_reset();

        wq.delete();
        push_period(2, 0);
        for (int i = 0; i < 7; i++) push_period(DIV, int'($urandom_range(2, 3)));
        while (wq.size() > 0) begin
            b = wq.pop_front();
            step(b, 1'b1, 1'b0);
            if (got_v !== exp_vec()) begin
                errors++;
                $display("FAIL relock edge=%0d got=%h expected=%h", n - 1, got_v, exp_vec());
            end
            checks++;
        end
        p_before = m_period;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (got_v !== exp_vec()) begin
                errors++;
                $display("FAIL en_off edge=%0d got=%h expected=%h", n - 1, got_v, exp_vec());
            end
            checks++;
        end
        if (locked !== 1'b0 || period !== CW'(p_before)) begin
            errors++;
            $display("FAIL en_off_hold locked=%b period=%0d expected locked=0 period=%0d",
                     locked, period, p_before);
        end
        checks++;
    endtask

    task automatic test_random();
        bit b;
        int p, h;
        wq.delete();
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0: p = DIV - 1;
                1: p = DIV + 1;
                2: p = DIV + 3;
                default: p = DIV;
            endcase
            h = ($urandom_range(0, 3) != 0) ? int'($urandom_range(2, 3))
                                            : int'($urandom_range(1, p - 1));
            push_period(p, h);
        end
        while (wq.size() > 0) begin
            b = wq.pop_front();
            step(b, $urandom_range(0, 149) != 0, $urandom_range(0, 15) == 0);
            if (got_v !== exp_vec()) begin
                errors++;
                $display("FAIL random edge=%0d got=%h expected=%h", n - 1, got_v, exp_vec());
            end
            checks++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock();
        test_bad_period();
        test_timeout();
        test_duty();
        test_err_clr();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
